// File: rtl/virtq_notify_arbiter.sv
// rtl/virtq_notify_arbiter.sv - per-queue notify coalescing with round-robin event hand-off
//
// Build option: VIRTQ_NOTIFY_COALESCE_EN
//   defined   : each queue keeps a saturating CNT_W-bit notification count and
//               evt_count reports how many notifies were merged into the event.
//   undefined : each queue keeps only a pending flag, evt_count is 1 for every
//               event and sat stays 0.
//
// Ports:
//   clk          in   clock (CSR domain)
//   csr_rst      in   synchronous active-high reset
//   notify_valid in   one-cycle pulse, a queue_notify write occurred
//   notify_qid   in   queue index of that write
//   queue_enable in   per-queue enable; a disabled queue drops and clears its count
//   evt_valid    out  event presented in the output slot
//   evt_qid      out  queue of the presented event
//   evt_count    out  notifications merged into the presented event
//   evt_ready    in   consumer accepts the presented event
//   pending      out  per-queue count is non-zero
//   bad_qid      out  one-cycle pulse, previous notify had an out-of-range index
//   sat          out  sticky per-queue counter-saturated flag
module virtq_notify_arbiter #(
    parameter int NUM_QUEUES = 3,
    parameter int QID_W      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  csr_rst,
    input  logic                  notify_valid,
    input  logic [QID_W-1:0]      notify_qid,
    input  logic [NUM_QUEUES-1:0] queue_enable,
    output logic                  evt_valid,
    output logic [QID_W-1:0]      evt_qid,
    output logic [CNT_W-1:0]      evt_count,
    input  logic                  evt_ready,
    output logic [NUM_QUEUES-1:0] pending,
    output logic                  bad_qid,
    output logic [NUM_QUEUES-1:0] sat
);

`ifdef VIRTQ_NOTIFY_COALESCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit               SAT_EN  = 1'b1;
`else
    // Counter collapses to a flag: it can only ever hold 0 or 1.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1);
    localparam bit               SAT_EN  = 1'b0;
`endif

    logic [CNT_W-1:0]      cnt      [NUM_QUEUES];
    logic [CNT_W-1:0]      cnt_next [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] sat_set;
    logic [NUM_QUEUES-1:0] notify_hit;
    logic [QID_W-1:0]      rr_ptr;
    logic [QID_W-1:0]      rr_next;
    logic                  sel_found;
    logic                  hi_found;
    logic [QID_W-1:0]      hi_idx;
    logic [QID_W-1:0]      lo_idx;
    logic [QID_W-1:0]      sel_idx;
    logic [CNT_W-1:0]      sel_cnt;
    logic                  slot_free;
    logic                  load;
    logic                  qid_in_range;
    logic [CNT_W-1:0]      base;

    // pending is a pure function of the count registers, no input feeds it.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            pending[i] = (cnt[i] != '0);
        end
    end

    // An out-of-range index never matches any queue, so it is dropped here.
    always_comb begin
        notify_hit = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            notify_hit[i] = notify_valid && queue_enable[i] && (notify_qid == QID_W'(i));
        end
    end

    assign qid_in_range = ({1'b0, notify_qid} < (QID_W + 1)'(NUM_QUEUES));

    // Round-robin: lowest pending index at or above rr_ptr wins; if none,
    // wrap around to the lowest pending index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_idx = QID_W'(i);
            end
            if (pending[i] && (QID_W'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = QID_W'(i);
            end
        end
        sel_found = |pending;
        sel_idx   = hi_found ? hi_idx : lo_idx;
        sel_cnt   = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (QID_W'(i) == sel_idx) begin
                sel_cnt = cnt[i];
            end
        end
    end

    assign rr_next   = (sel_idx == QID_W'(NUM_QUEUES - 1)) ? '0 : sel_idx + QID_W'(1);
    assign slot_free = !evt_valid || evt_ready;
    assign load      = slot_free && sel_found;

    // Counter next state. A load clears the count first, then a same-cycle
    // notify is applied on top, so a colliding notify leaves the count at 1.
    always_comb begin
        sat_set = '0;
        base    = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            base = (load && (sel_idx == QID_W'(i))) ? '0 : cnt[i];
            if (!queue_enable[i]) begin
                cnt_next[i] = '0;
            end else if (notify_hit[i]) begin
                if (base == CNT_MAX) begin
                    cnt_next[i] = base;
                    sat_set[i]  = SAT_EN;
                end else begin
                    cnt_next[i] = base + CNT_W'(1);
                end
            end else begin
                cnt_next[i] = base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (csr_rst) begin
            evt_valid <= 1'b0;
            evt_qid   <= '0;
            evt_count <= '0;
            rr_ptr    <= '0;
            bad_qid   <= 1'b0;
            sat       <= '0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // The slot only changes when empty or being accepted, so the
            // presented qid/count hold while the consumer stalls.
            if (slot_free) begin
                evt_valid <= sel_found;
                if (sel_found) begin
                    evt_qid   <= sel_idx;
                    evt_count <= sel_cnt;
                    rr_ptr    <= rr_next;
                end
            end
            bad_qid <= notify_valid && !qid_in_range;
            sat     <= sat | sat_set;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule
